// File: rtl/bf_loop_ctrl.sv
// Loop controller for the brainfuck core: drives loop_stack push/pop for '[' / ']',
// issues PC jumps back to loop heads, and runs forward-skip over zero-cell loops.
module bf_loop_ctrl #(
    parameter int ADDR_W      = 10,
    parameter int STACK_DEPTH = 16,
    parameter int SKIP_W      = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst,
    input  logic                             i_instr_valid,
    input  logic                             i_is_open,
    input  logic                             i_is_close,
    input  logic                             i_cell_zero,
    input  logic [ADDR_W-1:0]                i_pc,
    input  logic [ADDR_W-1:0]                i_stk_top,
    output logic                             o_stk_push,
    output logic                             o_stk_pop,
    output logic [ADDR_W-1:0]                o_stk_addr_in,
    output logic                             o_jump_valid,
    output logic [ADDR_W-1:0]                o_jump_addr,
    output logic                             o_skip,
    output logic [$clog2(STACK_DEPTH+1)-1:0] o_depth,
    output logic                             o_err
);

    localparam int DEPTH_W = $clog2(STACK_DEPTH + 1);
    localparam logic [DEPTH_W-1:0] DEPTH_FULL = DEPTH_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        SKIP = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t              r_state,   w_state_nxt;
    logic [DEPTH_W-1:0]  r_depth,   w_depth_nxt;
    logic [SKIP_W-1:0]   r_skip_cnt, w_skip_nxt;
    logic                r_push,    w_push;
    logic                r_pop,     w_pop;
    logic                r_jump,    w_jump;
    logic [ADDR_W-1:0]   r_addr_in, w_addr_in;
    logic [ADDR_W-1:0]   r_jaddr,   w_jaddr;
    logic [ADDR_W-1:0]   w_pc_inc;

    assign w_pc_inc = i_pc + ADDR_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= RUN;
            r_depth    <= '0;
            r_skip_cnt <= '0;
            r_push     <= 1'b0;
            r_pop      <= 1'b0;
            r_jump     <= 1'b0;
            r_addr_in  <= '0;
            r_jaddr    <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_depth    <= w_depth_nxt;
            r_skip_cnt <= w_skip_nxt;
            r_push     <= w_push;
            r_pop      <= w_pop;
            r_jump     <= w_jump;
            r_addr_in  <= w_addr_in;
            r_jaddr    <= w_jaddr;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_depth_nxt = r_depth;
        w_skip_nxt  = r_skip_cnt;
        w_push      = 1'b0;
        w_pop       = 1'b0;
        w_jump      = 1'b0;
        w_addr_in   = '0;
        w_jaddr     = '0;
        if (i_instr_valid) begin
            unique case (r_state)
                RUN: begin
                    if (i_is_open && i_is_close) begin
                        w_state_nxt = ERR;
                    end else if (i_is_open) begin
                        if (i_cell_zero) begin
                            w_state_nxt = SKIP;
                            w_skip_nxt  = SKIP_W'(1);
                        end else if (r_depth == DEPTH_FULL) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_push      = 1'b1;
                            w_addr_in   = w_pc_inc;
                            w_depth_nxt = r_depth + DEPTH_W'(1);
                        end
                    end else if (i_is_close) begin
                        if (r_depth == '0) begin
                            w_state_nxt = ERR;
                        end else if (!i_cell_zero) begin
                            // Loop again: the stack entry stays live for the next ']'
                            w_jump  = 1'b1;
                            w_jaddr = i_stk_top;
                        end else begin
                            w_pop       = 1'b1;
                            w_depth_nxt = r_depth - DEPTH_W'(1);
                        end
                    end
                end
                SKIP: begin
                    if (i_is_open && i_is_close) begin
                        w_state_nxt = ERR;
                    end else if (i_is_open) begin
                        if (r_skip_cnt == '1) begin
                            w_state_nxt = ERR;
                        end else begin
                            w_skip_nxt = r_skip_cnt + SKIP_W'(1);
                        end
                    end else if (i_is_close) begin
                        w_skip_nxt = r_skip_cnt - SKIP_W'(1);
                        if (r_skip_cnt == SKIP_W'(1)) begin
                            w_state_nxt = RUN;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ERR;
                end
            endcase
        end
    end

    assign o_stk_push    = r_push;
    assign o_stk_pop     = r_pop;
    assign o_stk_addr_in = r_addr_in;
    assign o_jump_valid  = r_jump;
    assign o_jump_addr   = r_jaddr;
    assign o_depth       = r_depth;
    assign o_skip        = (r_state != RUN);
    assign o_err         = (r_state == ERR);

endmodule

// File: tb/tb_bf_loop_ctrl.sv
// Directed bench for bf_loop_ctrl: push/jump/pop, forward skip, overflow,
// underflow, pc wrap and the invalid open+close combination.
module tb_bf_loop_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instrValid = 1'b0;
    logic        isOpen = 1'b0;
    logic        isClose = 1'b0;
    logic        cellZero = 1'b0;
    logic [9:0]  pc = '0;
    logic [9:0]  stkTop = '0;
    logic        stkPush, stkPop, jumpValid, skip, err;
    logic [9:0]  stkAddrIn, jumpAddr;
    logic [4:0]  depth;

    int vecCount  = 0;
    int missCount = 0;
    int pushSeen  = 0;
    int popSeen   = 0;

    bf_loop_ctrl #(.ADDR_W(10), .STACK_DEPTH(16), .SKIP_W(8)) dut (
        .i_clk(clk), .i_rst(rst), .i_instr_valid(instrValid),
        .i_is_open(isOpen), .i_is_close(isClose), .i_cell_zero(cellZero),
        .i_pc(pc), .i_stk_top(stkTop),
        .o_stk_push(stkPush), .o_stk_pop(stkPop), .o_stk_addr_in(stkAddrIn),
        .o_jump_valid(jumpValid), .o_jump_addr(jumpAddr),
        .o_skip(skip), .o_depth(depth), .o_err(err)
    );

    always #5 clk = ~clk;

    // Pulse counters used to prove the skip region never touches the stack
    always @(posedge clk) begin
        if (stkPush) pushSeen++;
        if (stkPop)  popSeen++;
    end

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        instrValid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drive(input logic v, input logic o, input logic c,
                         input logic z, input logic [9:0] p, input logic [9:0] t);
        @(negedge clk);
        instrValid = v; isOpen = o; isClose = c; cellZero = z; pc = p; stkTop = t;
        @(posedge clk);
        #1 instrValid = 1'b0; isOpen = 1'b0; isClose = 1'b0;
    endtask

    task automatic test_reset();
        doReset();
        vecCount++; if (stkPush !== 1'b0) begin missCount++; $display("[TB] FAIL reset_push got %b exp 0", stkPush); end
        vecCount++; if (stkPop !== 1'b0) begin missCount++; $display("[TB] FAIL reset_pop got %b exp 0", stkPop); end
        vecCount++; if (jumpValid !== 1'b0) begin missCount++; $display("[TB] FAIL reset_jump got %b exp 0", jumpValid); end
        vecCount++; if (skip !== 1'b0) begin missCount++; $display("[TB] FAIL reset_skip got %b exp 0", skip); end
        vecCount++; if (err !== 1'b0) begin missCount++; $display("[TB] FAIL reset_err got %b exp 0", err); end
        vecCount++; if (depth !== 5'd0) begin missCount++; $display("[TB] FAIL reset_depth got %0d exp 0", depth); end
    endtask

    task automatic test_push_jump_pop();
        drive(1, 1, 0, 0, 10'h005, 10'h000);
        vecCount++; if (stkPush !== 1'b1) begin missCount++; $display("[TB] FAIL open_push got %b exp 1", stkPush); end
        vecCount++; if (stkAddrIn !== 10'h006) begin missCount++; $display("[TB] FAIL open_addr got %h exp 006", stkAddrIn); end
        vecCount++; if (depth !== 5'd1) begin missCount++; $display("[TB] FAIL open_depth got %0d exp 1", depth); end
        drive(1, 0, 1, 0, 10'h00A, 10'h006);
        vecCount++; if (jumpValid !== 1'b1) begin missCount++; $display("[TB] FAIL close_jump got %b exp 1", jumpValid); end
        vecCount++; if (jumpAddr !== 10'h006) begin missCount++; $display("[TB] FAIL close_jaddr got %h exp 006", jumpAddr); end
        vecCount++; if (stkPop !== 1'b0) begin missCount++; $display("[TB] FAIL close_nopop got %b exp 0", stkPop); end
        vecCount++; if (depth !== 5'd1) begin missCount++; $display("[TB] FAIL close_depth got %0d exp 1", depth); end
        drive(1, 0, 1, 1, 10'h00A, 10'h006);
        vecCount++; if (stkPop !== 1'b1) begin missCount++; $display("[TB] FAIL exit_pop got %b exp 1", stkPop); end
        vecCount++; if (jumpValid !== 1'b0) begin missCount++; $display("[TB] FAIL exit_nojump got %b exp 0", jumpValid); end
        vecCount++; if (depth !== 5'd0) begin missCount++; $display("[TB] FAIL exit_depth got %0d exp 0", depth); end
    endtask

    task automatic test_skip();
        drive(1, 1, 0, 1, 10'h010, 10'h000);
        pushSeen = 0; popSeen = 0;
        vecCount++; if (skip !== 1'b1) begin missCount++; $display("[TB] FAIL skip_enter got %b exp 1", skip); end
        drive(1, 1, 0, 1, 10'h011, 10'h000);
        vecCount++; if (skip !== 1'b1) begin missCount++; $display("[TB] FAIL skip_nest got %b exp 1", skip); end
        drive(1, 0, 1, 0, 10'h012, 10'h000);
        vecCount++; if (skip !== 1'b1) begin missCount++; $display("[TB] FAIL skip_close1 got %b exp 1", skip); end
        drive(1, 0, 0, 0, 10'h013, 10'h000);
        vecCount++; if (skip !== 1'b1) begin missCount++; $display("[TB] FAIL skip_plus got %b exp 1", skip); end
        drive(1, 0, 1, 1, 10'h014, 10'h000);
        vecCount++; if (skip !== 1'b0) begin missCount++; $display("[TB] FAIL skip_exit got %b exp 0", skip); end
        vecCount++; if (err !== 1'b0) begin missCount++; $display("[TB] FAIL skip_err got %b exp 0", err); end
        @(posedge clk); #1;
        vecCount++; if (pushSeen !== 0 || popSeen !== 0) begin missCount++; $display("[TB] FAIL skip_stack got push=%0d pop=%0d exp 0/0", pushSeen, popSeen); end
        vecCount++; if (depth !== 5'd0) begin missCount++; $display("[TB] FAIL skip_depth got %0d exp 0", depth); end
        drive(1, 1, 0, 1, 10'h020, 10'h000);
        doReset();
        vecCount++; if (skip !== 1'b0) begin missCount++; $display("[TB] FAIL skip_rst got %b exp 0", skip); end
    endtask

    task automatic test_overflow();
        doReset();
        for (int i = 0; i < 16; i++) drive(1, 1, 0, 0, 10'(i * 2), 10'h000);
        vecCount++; if (stkPush !== 1'b1) begin missCount++; $display("[TB] FAIL ovf_lastpush got %b exp 1", stkPush); end
        vecCount++; if (stkAddrIn !== 10'h01F) begin missCount++; $display("[TB] FAIL ovf_lastaddr got %h exp 01f", stkAddrIn); end
        vecCount++; if (depth !== 5'd16) begin missCount++; $display("[TB] FAIL ovf_full got %0d exp 16", depth); end
        drive(1, 1, 0, 0, 10'h040, 10'h000);
        vecCount++; if (err !== 1'b1) begin missCount++; $display("[TB] FAIL ovf_err got %b exp 1", err); end
        vecCount++; if (stkPush !== 1'b0) begin missCount++; $display("[TB] FAIL ovf_nopush got %b exp 0", stkPush); end
        vecCount++; if (depth !== 5'd16) begin missCount++; $display("[TB] FAIL ovf_depth got %0d exp 16", depth); end
        drive(1, 0, 1, 1, 10'h041, 10'h01F);
        vecCount++; if (stkPop !== 1'b0) begin missCount++; $display("[TB] FAIL ovf_ignore_pop got %b exp 0", stkPop); end
        drive(1, 0, 1, 0, 10'h042, 10'h01F);
        vecCount++; if (jumpValid !== 1'b0) begin missCount++; $display("[TB] FAIL ovf_ignore_jump got %b exp 0", jumpValid); end
        vecCount++; if (err !== 1'b1 || skip !== 1'b1) begin missCount++; $display("[TB] FAIL ovf_sticky got err=%b skip=%b exp 1/1", err, skip); end
    endtask

    task automatic test_underflow();
        doReset();
        drive(1, 0, 1, 1, 10'h003, 10'h000);
        vecCount++; if (err !== 1'b1) begin missCount++; $display("[TB] FAIL unf_err got %b exp 1", err); end
        vecCount++; if (stkPop !== 1'b0) begin missCount++; $display("[TB] FAIL unf_nopop got %b exp 0", stkPop); end
        doReset();
        vecCount++; if (err !== 1'b0 || skip !== 1'b0) begin missCount++; $display("[TB] FAIL unf_rst got err=%b skip=%b exp 0/0", err, skip); end
    endtask

    task automatic test_wrap_and_conflict();
        drive(1, 1, 0, 0, 10'h3FF, 10'h000);
        vecCount++; if (stkAddrIn !== 10'h000 || stkPush !== 1'b1) begin missCount++; $display("[TB] FAIL wrap_addr got %h push=%b exp 000/1", stkAddrIn, stkPush); end
        drive(0, 1, 0, 0, 10'h100, 10'h000);
        vecCount++; if (stkPush !== 1'b0 || depth !== 5'd1) begin missCount++; $display("[TB] FAIL invalid_idle got push=%b depth=%0d exp 0/1", stkPush, depth); end
        drive(1, 1, 1, 0, 10'h101, 10'h000);
        vecCount++; if (err !== 1'b1) begin missCount++; $display("[TB] FAIL both_err got %b exp 1", err); end
        vecCount++; if (stkPush !== 1'b0 || stkPop !== 1'b0 || jumpValid !== 1'b0) begin missCount++; $display("[TB] FAIL both_noact got push=%b pop=%b jump=%b exp 0/0/0", stkPush, stkPop, jumpValid); end
    endtask

    initial begin
        test_reset();
        test_push_jump_pop();
        test_skip();
        test_overflow();
        test_underflow();
        test_wrap_and_conflict();
        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
